// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// Purpose:
//   Decode stage between fetch and execute. Reads two source operands from an
//   internal register file, resolves them through a forwarding network with
//   writeback write-through, detects load-use hazards and holds the decoded
//   instruction in a single registered output slot with a valid/ready
//   handshake. The architectural register state after the current cycle's
//   writeback is exported on next_reg for difftest.
//
// Configuration macro:
//   DECODE_FWD_EN - when defined, valid non-pending forwarding sources supply
//                   operand data. When undefined, fwd_data is ignored and any
//                   valid matching forwarding source is treated as a hazard.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   flush               drop the output slot and the incoming instruction
//   in_valid/in_ready   fetch handshake
//   in_pc .. in_imm     incoming instruction fields
//   fwd_valid/pending   per-source forwarding status (index 0 youngest)
//   fwd_addr/fwd_data   per-source destination and result, packed
//   wen/wa/wd           register file writeback
//   out_valid/out_ready execute handshake
//   out_*               registered instruction fields and resolved operands
//   next_reg            register file contents after this cycle's write
// -----------------------------------------------------------------------------
module decode_stage #(
   parameter  int XLEN = 64,
   parameter  int NREG = 32,
   parameter  int NFWD = 2,
   parameter  int CTLW = 32,
   localparam int AW   = $clog2(NREG)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [XLEN-1:0]      in_pc,
   input  logic [31:0]          in_instr,
   input  logic [CTLW-1:0]      in_ctl,
   input  logic [AW-1:0]        in_ra1,
   input  logic [AW-1:0]        in_ra2,
   input  logic [AW-1:0]        in_dst,
   input  logic [XLEN-1:0]      in_imm,
   input  logic [NFWD-1:0]      fwd_valid,
   input  logic [NFWD-1:0]      fwd_pending,
   input  logic [NFWD*AW-1:0]   fwd_addr,
   input  logic [NFWD*XLEN-1:0] fwd_data,
   input  logic                 wen,
   input  logic [AW-1:0]        wa,
   input  logic [XLEN-1:0]      wd,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_pc,
   output logic [31:0]          out_instr,
   output logic [CTLW-1:0]      out_ctl,
   output logic [AW-1:0]        out_ra1,
   output logic [AW-1:0]        out_ra2,
   output logic [AW-1:0]        out_dst,
   output logic [XLEN-1:0]      out_imm,
   output logic [XLEN-1:0]      out_srca,
   output logic [XLEN-1:0]      out_srcb,
   output logic [NREG*XLEN-1:0] next_reg
);

   logic [XLEN-1:0] regs_r [NREG];
   logic [XLEN:0]   res_a_s;      // {hazard, data} for source 1
   logic [XLEN:0]   res_b_s;      // {hazard, data} for source 2
   logic            hazard_s;
   logic            accept_s;
   logic            drain_s;

`ifndef DECODE_FWD_EN
   // Forwarding data and pending status have no effect in this build.
   logic unused_fwd_s;
   assign unused_fwd_s = ^{fwd_data, fwd_pending};
`endif

   // Resolve one source address to {hazard, data}. The lowest-indexed valid
   // source that matches the address decides: a pending match is a hazard,
   // a ready match supplies its result. Without a match the writeback
   // write-through or the register file supplies the value. x0 always reads
   // as zero and never stalls.
   function automatic logic [XLEN:0] resolve(input logic [AW-1:0] ra);
      logic [XLEN-1:0] data_v;
      logic            haz_v;
      logic            hit_v;
      haz_v = 1'b0;
      hit_v = 1'b0;
      if (wen && (wa == ra)) begin
         data_v = wd;
      end else begin
         data_v = regs_r[ra];
      end
      for (int i = 0; i < NFWD; i++) begin
         if (!hit_v && fwd_valid[i] && (fwd_addr[i*AW +: AW] == ra)) begin
            hit_v = 1'b1;
`ifdef DECODE_FWD_EN
            if (fwd_pending[i]) begin
               haz_v = 1'b1;
            end else begin
               data_v = fwd_data[i*XLEN +: XLEN];
            end
`else
            haz_v = 1'b1;
`endif
         end else begin
            hit_v = hit_v;
         end
      end
      if (ra == {AW{1'b0}}) begin
         data_v = {XLEN{1'b0}};
         haz_v  = 1'b0;
      end else begin
         haz_v  = haz_v;
      end
      return {haz_v, data_v};
   endfunction

   // Operand resolution and handshake decisions for this cycle.
   always_comb begin
      res_a_s  = resolve(in_ra1);
      res_b_s  = resolve(in_ra2);
      hazard_s = in_valid && (res_a_s[XLEN] || res_b_s[XLEN]);
      in_ready = !hazard_s && (!out_valid || out_ready);
      accept_s = in_valid && in_ready && !flush;
      drain_s  = out_valid && out_ready;
   end

   // Difftest view: register file as it will be after this edge.
   always_comb begin
      next_reg = {(NREG*XLEN){1'b0}};
      for (int i = 0; i < NREG; i++) begin
         if (reset) begin
            next_reg[i*XLEN +: XLEN] = {XLEN{1'b0}};
         end else if (wen && (wa == AW'(i)) && (i != 0)) begin
            next_reg[i*XLEN +: XLEN] = wd;
         end else begin
            next_reg[i*XLEN +: XLEN] = regs_r[i];
         end
      end
   end

   // Register file: cleared on reset, x0 never written. Writeback proceeds
   // independently of flush and stalls.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs_r[i] <= {XLEN{1'b0}};
         end
      end else if (wen && (wa != {AW{1'b0}})) begin
         regs_r[wa] <= wd;
      end else begin
         regs_r[wa] <= regs_r[wa];
      end
   end

   // Output slot: reset beats flush, flush beats accept. Fields only load on
   // accept, so a stalled slot keeps the operands captured at its accept edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_pc    <= {XLEN{1'b0}};
         out_instr <= 32'h0000_0000;
         out_ctl   <= {CTLW{1'b0}};
         out_ra1   <= {AW{1'b0}};
         out_ra2   <= {AW{1'b0}};
         out_dst   <= {AW{1'b0}};
         out_imm   <= {XLEN{1'b0}};
         out_srca  <= {XLEN{1'b0}};
         out_srcb  <= {XLEN{1'b0}};
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept_s) begin
         out_valid <= 1'b1;
         out_pc    <= in_pc;
         out_instr <= in_instr;
         out_ctl   <= in_ctl;
         out_ra1   <= in_ra1;
         out_ra2   <= in_ra2;
         out_dst   <= in_dst;
         out_imm   <= in_imm;
         out_srca  <= res_a_s[XLEN-1:0];
         out_srcb  <= res_b_s[XLEN-1:0];
      end else if (drain_s) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= out_valid;
      end
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Parametrised decode stage. It reads operands from an internal register file, resolves them through a forwarding network, and detects load-use hazards. Results are held in a registered output slot with a valid/ready handshake. It sits between fetch and execute, and its single output slot lets it stall or flush independently. It also exports the architectural register state for difftest.

Parameters:
XLEN, 64, data/register width in bits
NREG, 32, architectural registers; x0 hardwired zero; address width AW = $clog2(NREG)
NFWD, 2, forwarding source count; index 0 is the youngest and has highest priority
CTLW, 32, width of opaque control bundle passed through

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  discard the output slot and the incoming instruction this cycle
in_valid  in  1  fetch offers an instruction
in_ready  out  1  decode accepts this cycle
in_pc  in  XLEN  instruction PC
in_instr  in  32  raw instruction
in_ctl  in  CTLW  pre-decoded control
in_ra1, in_ra2  in  AW  source register addresses
in_dst  in  AW  destination register
in_imm  in  XLEN  immediate
fwd_valid  in  NFWD  source i holds a valid result
fwd_pending  in  NFWD  source i will write fwd_addr[i] but its data is not ready yet (load)
fwd_addr  in  NFWD*AW  destination of source i
fwd_data  in  NFWD*XLEN  result of source i
wen  in  1  writeback enable
wa  in  AW  writeback address
wd  in  XLEN  writeback data
out_valid  out  1  output slot occupied
out_ready  in  1  execute consumes the slot
out_pc, out_instr, out_ctl, out_ra1, out_ra2, out_dst, out_imm  out  as inputs  registered copies
out_srca, out_srcb  out  XLEN  resolved operands
next_reg  out  NREG*XLEN  register file contents after this cycle's write, for difftest

Behaviour:
- Reset (sync): all registers cleared to 0, x0..x(NREG-1) included; out_valid=0; every out_* field is 0.
- Register file: write at posedge when wen && wa!=0; writes to x0 are ignored. next_reg reflects the written value combinationally, during the same cycle as the write.
- Operand resolution is applied per source and evaluated in priority order:
  - address 0 gives 0;
  - otherwise the lowest i with fwd_valid[i] && !fwd_pending[i] && fwd_addr[i]==ra gives fwd_data[i];
  - otherwise wen && wa==ra gives wd (write-through);
  - otherwise the regfile value.
- Hazard: the lowest matching i with fwd_valid[i] && fwd_addr[i]==ra (ra!=0) has fwd_pending[i]=1. Lower-priority matches are masked.
- in_ready = !hazard && (!out_valid || out_ready). Hazard is evaluated only when in_valid=1.
- Accept (in_valid && in_ready && !flush): the slot is loaded next edge and out_valid=1. Latency is exactly 1 cycle.
- Slot drained without a new accept (out_valid && out_ready): out_valid goes 0.
- Hazard with a draining slot: out_valid goes 0, which inserts a bubble. Stall with a full, non-draining slot: the slot holds all fields stable.
- flush=1: out_valid goes 0 next edge regardless of the other inputs. The incoming instruction is dropped. Regfile writeback still occurs.
- A simultaneous drain and accept is a back-to-back transfer with no bubble.
- Operands are captured at the accept edge and are not re-resolved while the slot stalls.
- Reset mid-stall clears everything. Reset has priority over flush.

Optional Feature:
DECODE_FWD_EN:
- Defined: the forwarding network operates as described above.
- Undefined:
  - fwd_data is ignored.
  - Any fwd_valid[i] && fwd_addr[i]==ra (ra!=0) is a hazard, whether pending or not.
  - Operands come only from the wb write-through or the regfile.

Test Plan:
- Reset, then wen=1 wa=5 wd=0xDEAD. Next cycle, in ra1=5 → out_srca=0xDEAD one cycle after accept; next_reg[5]=0xDEAD.
- Same cycle: wen wa=3 wd=0x11 and in ra2=3 → out_srcb=0x11 (write-through); wa=0 write → next_reg[0] stays 0.
- fwd0 {addr=7,data=0xA} and fwd1 {addr=7,data=0xB} both valid, ra1=7 → out_srca=0xA. With DECODE_FWD_EN undefined → in_ready=0.
- fwd_pending[0]=1 addr=4, ra1=4 → in_ready=0 and a bubble is inserted. Next cycle pending=0 data=0x44 → accepted, out_srca=0x44.
- out_ready=0 for 3 cycles with out_valid=1 → out_* held; a new instruction waits. Then out_ready=1 and in_valid=1 → back-to-back transfer, no bubble.
- flush during an accept with out_valid=1 → out_valid=0 next cycle and the dropped PC never appears. A concurrent wen write still lands.
